uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_sync.sv | 25 ++
 rtl/uart_rx.sv | 143 ++++++++++++++
 tb/tb_uart_rx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default oversampling ratio.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b010,
    ST_START   = 3'b011,
    ST_DATA    = 3'b100,
    ST_STOP    = 3'b101,
    ST_RECOVER = 3'b110
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the async rx line; 2 clk latency, resets to idle-high.
// No backpressure: free-running sampler.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver; done pulses OVERSAMPLE/2 + 9*OVERSAMPLE clk after start detect.
// No backpressure: each byte is presented for one cycle on done and held on out.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_in,
  output logic [7:0] o_out,
  output logic       o_done,
  output logic       o_busy,
  output logic       o_err
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);

  if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_oversample
    $error("uart_rx: OVERSAMPLE must be even and at least 4");
  end

  uart_state_e      r_state;
  uart_state_e      w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_out;
  logic             r_done;
  logic             r_err;
  logic             w_rx_s;
  logic             w_busy;
  logic             w_bit_end;
  logic             w_half_bit;

  uart_rx_sync u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_in),
    .o_q     (w_rx_s)
  );

  assign w_bit_end  = (r_cnt == CNT_LAST);
  assign w_half_bit = (r_cnt == CNT_HALF);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_en && !w_rx_s) w_next_state = ST_START;
      end
      ST_START: begin
        // Mid-start-bit recheck rejects glitches shorter than half a bit.
        if (w_half_bit) w_next_state = w_rx_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (w_bit_end && (r_bit_idx == 3'd7)) w_next_state = ST_STOP;
      end
      ST_STOP: begin
        if (w_bit_end) w_next_state = w_rx_s ? ST_IDLE : ST_RECOVER;
      end
      ST_RECOVER: begin
        if (w_rx_s) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      ST_START, ST_DATA, ST_STOP, ST_RECOVER: w_busy = 1'b1;
      default:                                w_busy = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_out     <= 8'h00;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_START: begin
          if (w_half_bit) begin
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_shift[r_bit_idx] <= w_rx_s;
            r_bit_idx          <= r_bit_idx + 3'd1;
            r_cnt              <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_out  <= r_shift;
              r_done <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt     <= '0;
          r_bit_idx <= 3'd0;
        end
      endcase
    end
  end

  assign o_out  = r_out;
  assign o_done = r_done;
  assign o_err  = r_err;
  assign o_busy = w_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at OVERSAMPLE = 16: stimulus pushes expected pulses,
// a negedge monitor pops and compares them against done/err as they appear.
module tb_uart_rx;

  localparam int OS = 16;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       rx_line;
  logic [7:0] out;
  logic       done;
  logic       busy;
  logic       err;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_total;
  int   n_pass;
  int   cyc;
  int   rise_cyc;
  int   busy_cnt;
  logic busy_q;

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (en),
    .i_in    (rx_line),
    .o_out   (out),
    .o_done  (done),
    .o_busy  (busy),
    .o_err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_total++;
    if (got === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, got, req);
  endtask

  // Monitor: pops the scoreboard on every done/err pulse.
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_cnt++;
    if (busy && !busy_q) rise_cyc = cyc;
    busy_q = busy;
    if (done && err) check("done_err_together", 1, 0);
    else if (done || err) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, err, done}, 0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind_err", {31'd0, err}, {31'd0, e.is_err});
        check("pulse_out", {24'd0, out}, {24'd0, e.data});
        if (done) check("done_latency", rise_cyc <= cyc ? cyc - rise_cyc : -1, 152);
      end
    end
  end

  task automatic idle(input int n);
    rx_line = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx_line = b;
    repeat (OS) @(negedge clk);
  endtask

  // Start bit plus the first nbits data bits, LSB first.
  task automatic send_partial(input logic [7:0] d, input int nbits);
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(d[i]);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input bit push_exp,
                            input logic [7:0] exp_data);
    exp_t e;
    if (push_exp) begin
      e.is_err = !stop;
      e.data   = exp_data;
      sb.push_back(e);
    end
    send_partial(d, 8);
    drive_bit(stop);
  endtask

  initial begin
    bit en_dropped;
    n_total  = 0;
    n_pass   = 0;
    cyc      = 0;
    rise_cyc = 0;
    busy_cnt = 0;
    busy_q   = 1'b0;
    rst_n    = 1'b0;
    en       = 1'b1;
    rx_line  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_out", {24'd0, out}, 0);
    check("reset_done", {31'd0, done}, 0);
    check("reset_err", {31'd0, err}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    rst_n = 1'b1;
    idle(20);

    // Basic frame A5
    send_frame(8'hA5, 1'b1, 1, 8'hA5);
    idle(40);
    check("a5_drained", sb.size(), 0);

    // Back-to-back 00 then FF, no idle gap
    send_frame(8'h00, 1'b1, 1, 8'h00);
    send_frame(8'hFF, 1'b1, 1, 8'hFF);
    idle(40);
    check("b2b_drained", sb.size(), 0);

    // Short low glitch while idle
    busy_cnt = 0;
    rx_line = 1'b0;
    repeat (4) @(negedge clk);
    idle(30);
    check("glitch_busy_max8", busy_cnt <= 8 ? 1 : busy_cnt, 1);
    check("glitch_busy_seen", busy_cnt > 0 ? 1 : 0, 1);
    check("glitch_idle_after", {31'd0, busy}, 0);

    // Framing error then 40-bit break; out keeps FF
    send_frame(8'h3C, 1'b0, 1, 8'hFF);
    rx_line = 1'b0;
    repeat (40 * OS) @(negedge clk);
    check("break_busy_held", {31'd0, busy}, 1);
    check("break_out_kept", {24'd0, out}, 8'hFF);
    idle(4);
    check("break_busy_release", {31'd0, busy}, 0);
    idle(40);
    check("break_drained", sb.size(), 0);

    // Enable low for a whole frame: ignored
    en = 1'b0;
    busy_cnt = 0;
    send_frame(8'h55, 1'b1, 0, 8'h00);
    idle(40);
    check("en_off_no_busy", busy_cnt, 0);
    en = 1'b1;
    idle(10);

    // Enable dropped after start detect: frame completes
    en_dropped = 0;
    fork
      send_frame(8'h81, 1'b1, 1, 8'h81);
      begin
        for (int i = 0; i < 40 && !en_dropped; i++) begin
          @(negedge clk);
          if (busy) begin
            en = 1'b0;
            en_dropped = 1;
          end
        end
      end
    join
    check("en_drop_busy_seen", {31'd0, en_dropped}, 1);
    idle(40);
    check("en_drop_drained", sb.size(), 0);
    en = 1'b1;
    idle(10);

    // Reset in the middle of the data bits
    send_partial(8'h96, 4);
    rst_n   = 1'b0;
    rx_line = 1'b1;
    #1;
    check("midrst_out", {24'd0, out}, 0);
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_done", {31'd0, done}, 0);
    check("midrst_err", {31'd0, err}, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    idle(3 * OS * 10);
    check("midrst_no_pulse", sb.size(), 0);
    send_frame(8'h5A, 1'b1, 1, 8'h5A);
    idle(40);
    check("final_drained", sb.size(), 0);
    check("final_out", {24'd0, out}, 8'h5A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
